// File: rtl/cnn_input_pkg.sv
// Shared constants and sample type for the CNN input frame buffer.
// The CNN core reuses MEM_BITS for the width of its input port.
package cnn_input_pkg;

    localparam int DEPTH    = 200;
    localparam int WIDTH    = 12;
    localparam int COUNT_W  = 8;
    localparam int MEM_BITS = DEPTH * WIDTH;

    typedef logic [WIDTH-1:0] sample_t;

endpackage

// File: rtl/cnn_input_pack.sv
// Packs the twelve input pins into one sample word (pin0 is the MSB).
// Also decides whether the current write strobe targets a valid index.
module cnn_input_pack #(
    parameter int DEPTH   = cnn_input_pkg::DEPTH,
    parameter int COUNT_W = cnn_input_pkg::COUNT_W
) (
    input  logic                   write_en,
    input  logic [COUNT_W-1:0]     count,
    input  logic                   pin0,
    input  logic                   pin1,
    input  logic                   pin2,
    input  logic                   pin3,
    input  logic                   pin4,
    input  logic                   pin5,
    input  logic                   pin6,
    input  logic                   pin7,
    input  logic                   pin8,
    input  logic                   pin9,
    input  logic                   pin10,
    input  logic                   pin11,
    output cnn_input_pkg::sample_t word,
    output logic                   wr_valid,
    output logic                   wr_last
);

    assign word = {pin0, pin1, pin2, pin3, pin4, pin5,
                   pin6, pin7, pin8, pin9, pin10, pin11};

    // Out-of-range indices are dropped here, so they never touch storage or frame_done.
    assign wr_valid = write_en && (int'(count) < DEPTH);
    assign wr_last  = wr_valid && (int'(count) == DEPTH - 1);

endmodule

// File: rtl/cnn_input_memory.sv
// Frame input buffer: one sample per clock into a flat DEPTH*WIDTH register vector.
// Define CNN_INPUT_MEM_RESET_CLEAR_EN to make reset clear storage; by default storage has no reset.
module cnn_input_memory #(
    parameter int DEPTH   = cnn_input_pkg::DEPTH,
    parameter int WIDTH   = cnn_input_pkg::WIDTH,
    parameter int COUNT_W = cnn_input_pkg::COUNT_W
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     write_en,
    input  logic [COUNT_W-1:0]       count,
    input  logic                     pin0,
    input  logic                     pin1,
    input  logic                     pin2,
    input  logic                     pin3,
    input  logic                     pin4,
    input  logic                     pin5,
    input  logic                     pin6,
    input  logic                     pin7,
    input  logic                     pin8,
    input  logic                     pin9,
    input  logic                     pin10,
    input  logic                     pin11,
    output logic [0:DEPTH*WIDTH-1]   mem,
    output logic                     frame_done
);
    import cnn_input_pkg::*;

    sample_t word;
    logic    wr_valid;
    logic    wr_last;

    cnn_input_pack #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_pack (
        .write_en (write_en),
        .count    (count),
        .pin0     (pin0),
        .pin1     (pin1),
        .pin2     (pin2),
        .pin3     (pin3),
        .pin4     (pin4),
        .pin5     (pin5),
        .pin6     (pin6),
        .pin7     (pin7),
        .pin8     (pin8),
        .pin9     (pin9),
        .pin10    (pin10),
        .pin11    (pin11),
        .word     (word),
        .wr_valid (wr_valid),
        .wr_last  (wr_last)
    );

    // Ascending vector: the word MSB (pin0) lands at the lowest bit index of its slot.
    always_ff @(posedge clk) begin
`ifdef CNN_INPUT_MEM_RESET_CLEAR_EN
        if (rst_b) begin
            mem <= '0;
        end else if (wr_valid) begin
            mem[int'(count)*WIDTH +: WIDTH] <= word;
        end
`else
        if (!rst_b && wr_valid) begin
            mem[int'(count)*WIDTH +: WIDTH] <= word;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= wr_last;
        end
    end

endmodule

// File: tb/tb_cnn_input_memory.sv
// Self-checking bench for cnn_input_memory; expectations come from a word model and a scoreboard queue.
// Honours CNN_INPUT_MEM_RESET_CLEAR_EN to pick the reset behaviour of storage.
module tb_cnn_input_memory;
    import cnn_input_pkg::*;

    typedef struct {
        int          idx;
        logic [11:0] word;
        logic        fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    logic write_en;
    logic [7:0] count;
    logic pin0, pin1, pin2, pin3, pin4, pin5, pin6, pin7, pin8, pin9, pin10, pin11;
    logic [0:MEM_BITS-1] mem;
    logic frame_done;

    exp_t        sb[$];
    logic [11:0] model [0:DEPTH-1];
    int pass_cnt = 0;
    int total_cnt = 0;
    int fd_seen = 0;

    always #5 clk = ~clk;

    cnn_input_memory dut (
        .clk(clk), .rst_b(rst_b), .write_en(write_en), .count(count),
        .pin0(pin0), .pin1(pin1), .pin2(pin2), .pin3(pin3),
        .pin4(pin4), .pin5(pin5), .pin6(pin6), .pin7(pin7),
        .pin8(pin8), .pin9(pin9), .pin10(pin10), .pin11(pin11),
        .mem(mem), .frame_done(frame_done)
    );

    task automatic set_pins(input logic [11:0] w);
        {pin0, pin1, pin2, pin3, pin4, pin5, pin6, pin7, pin8, pin9, pin10, pin11} = w;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic check_word(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs == exp) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_mem(input string tag);
        logic [0:MEM_BITS-1] ev;
        int bad;
        bad = -1;
        for (int k = 0; k < DEPTH; k++) begin
            ev[k*12 +: 12] = model[k];
            if (bad < 0 && mem[k*12 +: 12] !== model[k]) bad = k;
        end
        if (bad < 0) bad = 0;
        total_cnt++;
        assert (mem === ev) pass_cnt++;
        else $error("FAIL %s: word %0d got %h expected %h", tag, bad, mem[bad*12 +: 12], model[bad]);
    endtask

    task automatic drive(input logic en, input int cnt, input logic [11:0] w);
        exp_t e;
        @(negedge clk);
        write_en = en;
        count = 8'(cnt);
        set_pins(w);
        if (en && cnt < DEPTH) begin
            model[cnt] = w;
            sb.push_back('{cnt, w, (cnt == DEPTH - 1)});
        end else begin
            sb.push_back('{-1, 12'h000, 1'b0});
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (frame_done === 1'b1) fd_seen++;
        check_bit("frame_done", frame_done, e.fd);
        if (e.idx >= 0) check_word($sformatf("word[%0d]", e.idx), mem[e.idx*12 +: 12], e.word);
    endtask

    task automatic idle(input int n, input bit toggle, input bit chk_mem);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            write_en = 1'b0;
            count = 8'($urandom_range(0, 255));
            if (toggle) set_pins(12'($urandom));
            sb.push_back('{-1, 12'h000, 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            if (frame_done === 1'b1) fd_seen++;
            check_bit("idle_frame_done", frame_done, e.fd);
            if (chk_mem) check_mem("idle_hold");
        end
    endtask

    task automatic reset_step(input int cnt, input logic [11:0] w);
        @(negedge clk);
        rst_b = 1'b1;
        write_en = 1'b1;
        count = 8'(cnt);
        set_pins(w);
`ifdef CNN_INPUT_MEM_RESET_CLEAR_EN
        for (int k = 0; k < DEPTH; k++) model[k] = 12'h000;
`endif
        @(posedge clk);
        #1;
        check_bit("reset_frame_done", frame_done, 1'b0);
        check_mem("reset_mem");
        @(negedge clk);
        rst_b = 1'b0;
        write_en = 1'b0;
    endtask

    initial begin
        rst_b = 1'b1;
        write_en = 1'b0;
        count = 8'd0;
        set_pins(12'h000);
        for (int k = 0; k < DEPTH; k++) begin
`ifdef CNN_INPUT_MEM_RESET_CLEAR_EN
            model[k] = 12'h000;
`else
            model[k] = 12'hxxx;
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        check_bit("por_frame_done", frame_done, 1'b0);
`ifdef CNN_INPUT_MEM_RESET_CLEAR_EN
        check_mem("por_mem_zero");
`endif
        @(negedge clk);
        rst_b = 1'b0;

        // Sequential frame, word = index
        fd_seen = 0;
        for (int k = 0; k < DEPTH; k++) drive(1'b1, k, 12'(k));
        idle(88, 1'b0, 1'b0);
        check_mem("seq_frame");
        check_int("fd_pulses_seq", fd_seen, 1);

        // Bit ordering
        drive(1'b1, 0, 12'h800);
        drive(1'b1, 1, 12'h001);
        check_bit("mem0", mem[0], 1'b1);
        check_word("mem1_11", {1'b0, mem[1 +: 11]}, 12'h000);
        check_bit("mem23", mem[23], 1'b1);
        check_word("mem12_22", {1'b0, mem[12 +: 11]}, 12'h000);

        // Out-of-range indices
        fd_seen = 0;
        drive(1'b1, 200, 12'hFFF);
        drive(1'b1, 255, 12'hFFF);
        check_mem("oob_mem");
        check_int("oob_fd", fd_seen, 0);

        // Hold with toggling pins, then single overwrite and repeated index
        idle(88, 1'b1, 1'b1);
        drive(1'b1, 5, 12'hABC);
        check_mem("overwrite5");
        check_word("slot5", mem[60 +: 12], 12'hABC);
        drive(1'b1, 7, 12'h123);
        drive(1'b1, 7, 12'h456);
        drive(1'b1, 150, 12'h0F0);
        check_mem("repeat_idx");

        // Reset mid-frame at count 100, then reset over a last-sample write
        fd_seen = 0;
        for (int k = 0; k < 100; k++) drive(1'b1, k, 12'(k) ^ 12'h5A5);
        reset_step(100, 12'h777);
        reset_step(DEPTH - 1, 12'h999);
        check_int("reset_fd", fd_seen, 0);

        // Full frame after reset
        fd_seen = 0;
        for (int k = 0; k < DEPTH; k++) drive(1'b1, k, 12'hFFF - 12'(k));
        idle(4, 1'b1, 1'b1);
        check_mem("post_reset_frame");
        check_int("fd_pulses_post", fd_seen, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
